// File: rtl/tile_row_streamer_pkg.sv
// Shared definitions for the tile row streamer: element width, tile-size helper, FSM states.
package tile_row_streamer_pkg;

  localparam int unsigned ELEM_WIDTH = 32;

  // Output size of the overlap processor for a square core input, kernel and stride.
  function automatic int unsigned calc_tile_dim(input int unsigned core_in,
                                                input int unsigned kernel,
                                                input int unsigned stride);
    return (core_in - kernel) / stride + 1;
  endfunction

  localparam int unsigned CORE_IN_DIM      = 8;
  localparam int unsigned KERNEL_DIM       = 3;
  localparam int unsigned STRIDE_DIM       = 1;
  localparam int unsigned TILE_DIM_DEFAULT = calc_tile_dim(CORE_IN_DIM, KERNEL_DIM, STRIDE_DIM);

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } state_e;

endpackage

// File: rtl/tile_row_streamer_slot_buffer.sv
// Two-entry tile register file: whole-tile write port and a row-select read port.
module tile_slot_buffer #(
  parameter int unsigned TILE_DIM   = tile_row_streamer_pkg::TILE_DIM_DEFAULT,
  parameter int unsigned ELEM_WIDTH = tile_row_streamer_pkg::ELEM_WIDTH,
  localparam int unsigned ROW_WIDTH  = TILE_DIM * ELEM_WIDTH,
  localparam int unsigned TILE_WIDTH = TILE_DIM * ROW_WIDTH,
  localparam int unsigned IDX_WIDTH  = (TILE_DIM > 1) ? $clog2(TILE_DIM) : 1
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic                  wr_ptr_i,
  input  logic [TILE_WIDTH-1:0] wr_data_i,
  input  logic                  rd_ptr_i,
  input  logic [IDX_WIDTH-1:0]  row_sel_i,
  output logic [ROW_WIDTH-1:0]  row_o
);

  // Contents are deliberately not reset; occupancy lives in the top level.
  logic [TILE_WIDTH-1:0] slot_q [2];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      slot_q[wr_ptr_i] <= wr_data_i;
    end
  end

  assign row_o = slot_q[rd_ptr_i][row_sel_i * ROW_WIDTH +: ROW_WIDTH];

endmodule

// File: rtl/tile_row_streamer.sv
// Captures whole tiles into a ping-pong store and streams them one row per valid/ready beat.
// Optional stall counter output enabled by defining TILE_ROW_STREAMER_PERF_EN.
module tile_row_streamer #(
  parameter int unsigned TILE_DIM   = tile_row_streamer_pkg::TILE_DIM_DEFAULT,
  parameter int unsigned ELEM_WIDTH = tile_row_streamer_pkg::ELEM_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned ROW_WIDTH  = TILE_DIM * ELEM_WIDTH,
  localparam int unsigned TILE_WIDTH = TILE_DIM * ROW_WIDTH,
  localparam int unsigned IDX_WIDTH  = (TILE_DIM > 1) ? $clog2(TILE_DIM) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [TILE_WIDTH-1:0] tile_i,
  input  logic                  tile_valid_i,
  output logic [ROW_WIDTH-1:0]  row_data_o,
  output logic                  row_valid_o,
  input  logic                  row_ready_i,
  output logic                  row_last_o,
  output logic [IDX_WIDTH-1:0]  row_idx_o,
  output logic                  full_o,
  output logic                  overflow_o,
  input  logic                  overflow_clr_i,
`ifdef TILE_ROW_STREAMER_PERF_EN
  output logic [31:0]           stall_cycles_o,
`endif
  output logic [CNT_WIDTH-1:0]  tiles_done_o
);

  import tile_row_streamer_pkg::*;

  localparam logic [IDX_WIDTH-1:0] LastRow = IDX_WIDTH'(TILE_DIM - 1);

  state_e                 state_q, state_d;
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             occ_q, occ_d;
  logic [IDX_WIDTH-1:0]   row_cnt_q;
  logic [CNT_WIDTH-1:0]   tiles_done_q;
  logic                   overflow_q;

  logic                   row_is_last;
  logic                   beat;
  logic                   rel;
  logic                   accept;
  logic                   drop;

  assign row_is_last = (row_cnt_q == LastRow);

  always_comb begin
    row_valid_o = (state_q == StStream);
    beat        = row_valid_o && row_ready_i;
    rel         = beat && row_is_last;
    // A release frees a slot in the same cycle, so a full store can still accept.
    accept      = tile_valid_i && ((occ_q != 2'd2) || rel);
    drop        = tile_valid_i && !accept;
    occ_d       = occ_q + 2'(accept) - 2'(rel);
    state_d     = state_q;
    unique case (state_q)
      StIdle:   if (occ_d != 2'd0) state_d = StStream;
      StStream: if (occ_d == 2'd0) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      occ_q        <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      row_cnt_q    <= '0;
      tiles_done_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      if (accept) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (beat) begin
        if (row_is_last) begin
          row_cnt_q    <= '0;
          rd_ptr_q     <= ~rd_ptr_q;
          tiles_done_q <= tiles_done_q + CNT_WIDTH'(1);
        end else begin
          row_cnt_q <= row_cnt_q + IDX_WIDTH'(1);
        end
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (overflow_clr_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  tile_slot_buffer #(
    .TILE_DIM   (TILE_DIM),
    .ELEM_WIDTH (ELEM_WIDTH)
  ) u_slot_buffer (
    .clk_i     (clk_i),
    .wr_en_i   (accept),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (tile_i),
    .rd_ptr_i  (rd_ptr_q),
    .row_sel_i (row_cnt_q),
    .row_o     (row_data_o)
  );

  assign row_last_o   = row_valid_o && row_is_last;
  assign row_idx_o    = row_cnt_q;
  assign full_o       = (occ_q == 2'd2);
  assign overflow_o   = overflow_q;
  assign tiles_done_o = tiles_done_q;

`ifdef TILE_ROW_STREAMER_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || overflow_clr_i) begin
      stall_q <= '0;
    end else if (row_valid_o && !row_ready_i && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule
